// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide, WIDTH iterations each,
// framed by a magnitude SETUP cycle and a sign-correcting FIX cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_req,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             rd_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    CALC  = 2'd2,
    FIX   = 2'd3
  } state_t;

  // Two's complement negation helpers for single and double width values.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_r;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]     count_r;
  logic                 sign_q_r;
  logic                 sign_r_r;
  logic                 b_zero_r;

  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_trial_s;
  logic [2*WIDTH-1:0]   div_next_s;

  // Operand magnitudes: only signed ops (op[0]=1) with a negative operand get negated.
  always_comb begin
    a_mag_s = a_r;
    b_mag_s = b_r;
    if (op_r[0] && a_r[WIDTH-1]) begin
      a_mag_s = neg_w(a_r);
    end else begin
      a_mag_s = a_r;
    end
    if (op_r[0] && b_r[WIDTH-1]) begin
      b_mag_s = neg_w(b_r);
    end else begin
      b_mag_s = b_r;
    end
  end

  // One iteration step. acc_r holds {upper, lower}: multiplier/quotient in the
  // lower half shifting out, partial product/remainder in the upper half.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  {1'b0, (acc_r[0] ? b_r : {WIDTH{1'b0}})};
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, b_r};
    if (div_trial_s[WIDTH] == 1'b0) begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end
  end

  // Stall is combinational so a held MFHI/MFLO is released the cycle done rises.
  assign stall = busy & (rd_req | start | mt_req);

  // Sequencer FSM with registered busy/done/div_by_zero and the HI/LO pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      op_r        <= 2'b00;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      count_r     <= {CNT_W{1'b0}};
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      b_zero_r    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !flush) begin
            op_r    <= op;
            a_r     <= a;
            b_r     <= b;
            busy    <= 1'b1;
            state_r <= SETUP;
          end else begin
            busy <= 1'b0;
            if (mt_req && !flush) begin
              if (mt_sel) begin
                hi <= mt_data;
              end else begin
                lo <= mt_data;
              end
            end
          end
        end
        SETUP: begin
          if (flush) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            acc_r    <= {{WIDTH{1'b0}}, a_mag_s};
            b_r      <= b_mag_s;
            sign_q_r <= op_r[0] & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            sign_r_r <= op_r[0] & a_r[WIDTH-1];
            b_zero_r <= op_r[1] & (b_r == {WIDTH{1'b0}});
            count_r  <= {CNT_W{1'b0}};
            state_r  <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            acc_r   <= op_r[1] ? div_next_s : mul_next_s;
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (count_r == CNT_W'(WIDTH-1)) begin
              state_r <= FIX;
            end
          end
        end
        FIX: begin
          if (flush) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            if (op_r[1]) begin
              lo <= sign_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
              hi <= sign_r_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            end else begin
              {hi, lo} <= sign_q_r ? neg_2w(acc_r) : acc_r;
            end
            done        <= 1'b1;
            div_by_zero <= b_zero_r;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected HI/LO results.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          mt_req;
  logic          mt_sel;
  logic [W-1:0]  mt_data;
  logic          rd_req;
  logic          flush;
  logic          busy;
  logic          stall;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mt_req(mt_req), .mt_sel(mt_sel), .mt_data(mt_data), .rd_req(rd_req),
    .flush(flush), .busy(busy), .stall(stall), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model built on 64-bit native arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    e.dbz = 1'b0;
    e.hi = 32'h0;
    e.lo = 32'h0;
    case (o)
      2'b00: begin p = {32'h0, x} * {32'h0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b10: begin
        if (y == 32'h0) begin e.lo = 32'hFFFFFFFF; e.hi = x; e.dbz = 1'b1; end
        else begin e.lo = x / y; e.hi = x % y; end
      end
      default: begin
        if (y == 32'h0) begin e.lo = x[31] ? 32'h00000001 : 32'hFFFFFFFF; e.hi = x; e.dbz = 1'b1; end
        else begin q = sx / sy; r = sx % sy; p = q; e.lo = p[31:0]; p = r; e.hi = p[31:0]; end
      end
    endcase
    return e;
  endfunction

  // Drive one start cycle; leaves the bench one #1 after the accepting edge (k=0).
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) sb_q.push_back(model(o, x, y));
  endtask

  // Wait (bounded) for done, then check latency, busy length, and the scoreboard head.
  task automatic wait_done(input string name, input int exp_lat);
    exp_t e;
    int k = 0;
    int busy_cnt = busy ? 1 : 0;
    while (k < 100 && !done) begin
      @(posedge clk); #1;
      k++;
      if (busy) busy_cnt++;
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL %s timeout: done not seen, required within 100 cycles", name);
    end else begin
      if (exp_lat > 0) begin
        tests++;
        if (k !== exp_lat) begin fails++; $display("FAIL %s latency: got %0d, required %0d", name, k, exp_lat); end
        tests++;
        if (busy_cnt !== exp_lat) begin fails++; $display("FAIL %s busy_len: got %0d, required %0d", name, busy_cnt, exp_lat); end
      end
      tests++;
      if (sb_q.size() == 0) begin
        fails++; $display("FAIL %s scoreboard: got empty queue, required an entry", name);
      end else begin
        e = sb_q.pop_front();
        tests++;
        if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz)
          begin fails++; $display("FAIL %s result: got hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b", name, hi, lo, div_by_zero, e.hi, e.lo, e.dbz); end
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL %s done_pulse: got done=%b one cycle later, required 0", name, done); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    mt_req = 1'b0; mt_sel = 1'b0; mt_data = 32'h0; rd_req = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || stall !== 1'b0)
      begin fails++; $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dbz=%b stall=%b, required all 0", hi, lo, busy, done, div_by_zero, stall); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    issue(2'b00, 32'd2, 32'd4, 1'b1);
    wait_done("multu_2x4", 34);
    tests++;
    if (hi !== 32'h0 || lo !== 32'h8) begin fails++; $display("FAIL multu_2x4_const: got %h_%h, required 00000000_00000008", hi, lo); end
    issue(2'b01, 32'hFFFFFFFD, 32'd5, 1'b1);
    wait_done("mult_m3x5", 34);
    tests++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin fails++; $display("FAIL mult_m3x5_const: got %h_%h, required FFFFFFFF_FFFFFFF1", hi, lo); end
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done("multu_max", 34);
    tests++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin fails++; $display("FAIL multu_max_const: got %h_%h, required FFFFFFFE_00000001", hi, lo); end
  endtask

  task automatic test_div();
    issue(2'b10, 32'd100, 32'd7, 1'b1);
    wait_done("divu_100_7", 34);
    tests++;
    if (hi !== 32'd2 || lo !== 32'd14) begin fails++; $display("FAIL divu_100_7_const: got hi=%h lo=%h, required hi=2 lo=14", hi, lo); end
    issue(2'b11, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done("div_m7_2", 34);
    tests++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_m7_2_const: got hi=%h lo=%h, required FFFFFFFF/FFFFFFFD", hi, lo); end
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done("div_overflow", 34);
    tests++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin fails++; $display("FAIL div_overflow_const: got hi=%h lo=%h, required 0/80000000", hi, lo); end
    issue(2'b10, 32'd5, 32'd0, 1'b1);
    wait_done("divu_by_zero", 34);
    tests++;
    if (hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL divu_by_zero_const: got hi=%h lo=%h, required 5/FFFFFFFF", hi, lo); end
    issue(2'b11, 32'hFFFFFFF0, 32'd0, 1'b1);
    wait_done("div_neg_by_zero", 34);
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (i[0]) y = y >> $urandom_range(0, 28);
      issue(o, x, y, 1'b1);
      wait_done($sformatf("random_%0d_op%0d", i, o), 34);
    end
  endtask

  task automatic test_stall_mt();
    exp_t e;
    issue(2'b00, 32'd2, 32'd4, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      if (k == 3) rd_req = 1'b1;
      #1;
      if (k < 3) begin
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL stall_no_req k=%0d: got %b, required 0", k, stall); end
      end else if (k <= 33) begin
        tests++;
        if (stall !== 1'b1) begin fails++; $display("FAIL stall_held k=%0d: got %b, required 1", k, stall); end
      end else begin
        e = sb_q.pop_front();
        tests++;
        if (stall !== 1'b0 || done !== 1'b1 || lo !== e.lo || hi !== e.hi)
          begin fails++; $display("FAIL stall_release: got stall=%b done=%b lo=%h, required stall=0 done=1 lo=%h", stall, done, lo, e.lo); end
      end
    end
    rd_req = 1'b0;
    @(posedge clk); #1;
    mt_req = 1'b1; mt_sel = 1'b0; mt_data = 32'h1234;
    @(posedge clk); #1;
    mt_req = 1'b0;
    tests++;
    if (lo !== 32'h1234 || hi !== 32'h0 || done !== 1'b0 || busy !== 1'b0)
      begin fails++; $display("FAIL mtlo: got lo=%h hi=%h done=%b busy=%b, required lo=1234 hi=0 done=0 busy=0", lo, hi, done, busy); end
    mt_req = 1'b1; mt_sel = 1'b1; mt_data = 32'hCAFE0001;
    @(posedge clk); #1;
    mt_req = 1'b0;
    tests++;
    if (hi !== 32'hCAFE0001 || lo !== 32'h1234 || done !== 1'b0)
      begin fails++; $display("FAIL mthi: got hi=%h lo=%h done=%b, required hi=CAFE0001 lo=1234 done=0", hi, lo, done); end
  endtask

  task automatic preload();
    mt_req = 1'b1; mt_sel = 1'b1; mt_data = 32'hAAAA0000;
    @(posedge clk); #1;
    mt_sel = 1'b0; mt_data = 32'h00005555;
    @(posedge clk); #1;
    mt_req = 1'b0;
  endtask

  task automatic test_flush_reset();
    int seen;
    preload();
    issue(2'b10, 32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hAAAA0000 || lo !== 32'h00005555)
      begin fails++; $display("FAIL flush_abort: got busy=%b done=%b hi=%h lo=%h, required 0/0/AAAA0000/00005555", busy, done, hi, lo); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    tests++;
    if (seen !== 0 || hi !== 32'hAAAA0000 || lo !== 32'h00005555)
      begin fails++; $display("FAIL flush_no_done: got %0d done pulses hi=%h lo=%h, required 0 and unchanged", seen, hi, lo); end
    issue(2'b10, 32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
      begin fails++; $display("FAIL reset_mid_op: got hi=%h lo=%h busy=%b done=%b, required all 0", hi, lo, busy, done); end
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL reset_no_done: got %0d busy/done cycles, required 0", seen); end
  endtask

  task automatic test_idle_conflicts();
    flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    mt_req = 1'b1; mt_sel = 1'b0; mt_data = 32'h77;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; mt_req = 1'b0;
    tests++;
    if (busy !== 1'b0 || lo !== 32'h0) begin fails++; $display("FAIL idle_flush_suppress: got busy=%b lo=%h, required busy=0 lo=0", busy, lo); end
    mt_req = 1'b1; mt_sel = 1'b1; mt_data = 32'h99;
    issue(2'b00, 32'd6, 32'd7, 1'b1);
    mt_req = 1'b0;
    tests++;
    if (busy !== 1'b1 || hi !== 32'h0) begin fails++; $display("FAIL start_wins_mt: got busy=%b hi=%h, required busy=1 hi=0", busy, hi); end
    wait_done("start_wins_result", 34);
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 32'd3, 32'd7, 1'b1);
    start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd8;
    sb_q.push_back(model(2'b10, 32'd50, 32'd8));
    repeat (5) begin @(posedge clk); #1; end
    tests++;
    if (stall !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL b2b_stall: got stall=%b busy=%b, required 1/1", stall, busy); end
    wait_done("b2b_first", -1);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy=%b, required 1", busy); end
    wait_done("b2b_second", -1);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_stall_mt();
    test_flush_reset();
    test_idle_conflicts();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair of the pipelined MIPS core.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the EX stage and runs a radix-2 shift-add / restoring-divide sequence over WIDTH cycles.
- Drives a stall request to the hazard logic while an MFHI/MFLO or a second HI/LO op would read or disturb an in-flight result.

Parameters:
WIDTH, 32, operand width; also the iteration count of the CALC state.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  EX-stage mult/div issue; qualified with op.
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
a  input  WIDTH  rs operand (multiplicand / dividend).
b  input  WIDTH  rt operand (multiplier / divisor).
mt_req  input  1  MTHI/MTLO in EX.
mt_sel  input  1  0 writes LO, 1 writes HI.
mt_data  input  WIDTH  MTHI/MTLO data.
rd_req  input  1  MFHI/MFLO in EX.
flush  input  1  pipeline flush; aborts the in-flight op.
busy  output  1  sequence in progress.
stall  output  1  hold upstream pipeline stages.
done  output  1  one-cycle pulse: HI/LO just updated by a mult/div.
div_by_zero  output  1  pulses with done when a DIV/DIVU had b==0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; internal accumulators cleared.
- FSM states: IDLE, SETUP, CALC, FIX.
  - IDLE: if start & ~flush, latch op, a and b, then go to SETUP.
  - SETUP (1 cycle): form magnitudes. For signed ops, take |a| and |b| and record sign_q=a[W-1]^b[W-1] and sign_r=a[W-1]. Unsigned ops use the operands raw. Load accumulator and count=0.
  - CALC (WIDTH cycles): one shift-add step (mult) or one restoring subtract step (div) per cycle. count increments each cycle; leave CALC when count==WIDTH-1.
  - FIX (1 cycle): apply sign correction.
    - Mult: negate the 2W-bit product if sign_q.
    - Div: negate quotient if sign_q; negate remainder if sign_r.
    - At the edge ending FIX: write hi/lo, go to IDLE, and set done=1 (plus div_by_zero if applicable) for exactly one cycle.
- Latency: with start sampled at edge E0, hi/lo change at edge E0+WIDTH+2 (34 for WIDTH=32). busy=1 in SETUP, CALC and FIX (WIDTH+2 cycles); busy=0 in IDLE.
- Result mapping:
  - Mult: {hi,lo} = full 2W-bit product.
  - Div: lo = quotient, hi = remainder. Remainder takes the sign of the dividend and the quotient truncates toward zero.
- Divide by zero: no trap, same latency. The natural restoring result is produced: lo = all ones for DIVU. For DIV, lo = all ones, negated if sign_q. hi = a. div_by_zero pulses with done.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- stall = busy & (rd_req | start | mt_req). This is combinational, with no registered delay. Stall drops in the cycle done is high, so the held MFHI/MFLO sees the new hi/lo.
- MTHI/MTLO: when ~busy & mt_req, write mt_data to the selected register at the next edge. This takes 1 cycle and does not assert done.
- Simultaneous events:
  - start and mt_req both high in IDLE: start wins and mt_req is ignored. The decoder never issues both.
  - start while busy: ignored, with stall asserted; it is accepted in the IDLE cycle after completion.
- flush:
  - In SETUP, CALC or FIX: return to IDLE at the next edge. hi/lo are unchanged, no done pulse, busy drops the next cycle.
  - In IDLE: also suppresses a same-cycle start or mt_req.
- Reset mid-operation: immediate return to the reset values above. No partial hi/lo update.

Test Plan:
1. MULTU a=2, b=4 → busy high 34 cycles, then hi=0x00000000, lo=0x00000008, done pulse exactly once.
2. MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
3. DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU 5/0 → lo=0xFFFFFFFF, hi=5, div_by_zero and done pulse together at cycle 34.
5. MULTU 2×4, then rd_req held high from cycle 3 → stall=1 cycles 3..33, stall=0 in the done cycle, lo reads 8. MTLO 0x1234 while idle → lo=0x1234 one cycle later, no done.
6. Preload hi=0xAAAA0000, lo=0x5555, start DIVU, then flush at cycle 10 (or pulse rst low at cycle 10) → state IDLE next cycle, no done. For flush, hi/lo keep 0xAAAA0000/0x5555. For reset, hi/lo read 0 immediately.
